// File: rtl/pic32_link_pkg.sv
// Shared definitions for the FPGA<->PIC32 nibble link: FSM states, widths and
// a helper for sizing down-counters.
package pic32_link_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_HI,
        WAIT_HI,
        SETUP_LO,
        WAIT_LO
    } link_state_e;

    // Width needed for a counter that must hold the larger of two load values.
    function automatic int cnt_width(input int a, input int b);
        int max_v;
        max_v = (a > b) ? a : b;
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/pic32_byte_fifo.sv
// Small synchronous byte FIFO with extra-bit pointers and registered
// full/empty flags; read data is the entry at the read pointer.
module pic32_byte_fifo
    import pic32_link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [BYTE_W-1:0] mem_reg [DEPTH];
    logic [PTR_W:0]    wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]    rd_ptr_reg, rd_ptr_next;
    logic              full_reg, full_next;
    logic              empty_reg, empty_next;
    logic              do_push, do_pop;

    // Requests are qualified by the registered flags only, so a pop never
    // frees a slot for a push in the same cycle.
    assign do_push = push & ~full_reg;
    assign do_pop  = pop & ~empty_reg;

    always_comb begin
        wr_ptr_next = do_push ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
        rd_ptr_next = do_pop  ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[PTR_W] != rd_ptr_next[PTR_W]) &&
                      (wr_ptr_next[PTR_W-1:0] == rd_ptr_next[PTR_W-1:0]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (do_push && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem_reg[rd_ptr_reg[PTR_W-1:0]];
    assign full    = full_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/pic32_nibble_transmitter.sv
// FPGA-to-PIC32 return path: buffers bytes and sends each as two nibbles
// (high first) using a two-phase strobe/ack toggle handshake.
module pic32_nibble_transmitter
    import pic32_link_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 4096
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [BYTE_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                pic_ack,
    output logic [NIBBLE_W-1:0] pic_data,
    output logic                pic_strobe,
    output logic                busy,
    output logic                timeout,
    input  logic                timeout_clear
);

    localparam int CNT_W = cnt_width(SETUP_CYCLES, ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] ACK_LOAD   = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;

    logic                ack_meta_reg, ack_s_reg;
    link_state_e         state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [NIBBLE_W-1:0] lo_nibble_reg, lo_nibble_next;
    logic [NIBBLE_W-1:0] pic_data_reg, pic_data_next;
    logic                strobe_reg, strobe_next;
    logic                timeout_reg, timeout_next;
    logic                timeout_set;

    logic                fifo_pop;
    logic [BYTE_W-1:0]   fifo_rd_data;
    logic                fifo_full, fifo_empty;

    pic32_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // pic_ack is asynchronous to clock; only the second flop feeds the FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta_reg <= 1'b0;
            ack_s_reg    <= 1'b0;
        end else begin
            ack_meta_reg <= pic_ack;
            ack_s_reg    <= ack_meta_reg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            lo_nibble_reg <= '0;
            pic_data_reg  <= '0;
            strobe_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            lo_nibble_reg <= lo_nibble_next;
            pic_data_reg  <= pic_data_next;
            strobe_reg    <= strobe_next;
            timeout_reg   <= timeout_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        lo_nibble_next = lo_nibble_reg;
        pic_data_next  = pic_data_reg;
        strobe_next    = strobe_reg;
        fifo_pop       = 1'b0;
        timeout_set    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop       = 1'b1;
                    pic_data_next  = fifo_rd_data[BYTE_W-1:NIBBLE_W];
                    lo_nibble_next = fifo_rd_data[NIBBLE_W-1:0];
                    cnt_next       = SETUP_LOAD;
                    state_next     = SETUP_HI;
                end
            end

            SETUP_HI, SETUP_LO: begin
                if (cnt_reg == '0) begin
                    strobe_next = ~strobe_reg;
                    cnt_next    = ACK_LOAD;
                    state_next  = (state_reg == SETUP_HI) ? WAIT_HI : WAIT_LO;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            WAIT_HI, WAIT_LO: begin
                if (ack_s_reg == strobe_reg) begin
                    if (state_reg == WAIT_HI) begin
                        pic_data_next = lo_nibble_reg;
                        cnt_next      = SETUP_LOAD;
                        state_next    = SETUP_LO;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (cnt_reg == '0) begin
                    // Abort the byte and copy the ack phase so the next byte
                    // starts from a matched strobe/ack pair.
                    timeout_set = 1'b1;
                    strobe_next = ack_s_reg;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (timeout_clear) begin
            timeout_next = 1'b0;
        end else if (timeout_set) begin
            timeout_next = 1'b1;
        end else begin
            timeout_next = timeout_reg;
        end
    end

    assign in_ready   = ~fifo_full;
    assign pic_data   = pic_data_reg;
    assign pic_strobe = strobe_reg;
    assign timeout    = timeout_reg;
    assign busy       = ~fifo_empty | (state_reg != IDLE);

endmodule

// File: tb/tb_pic32_nibble_transmitter.sv
// Directed bench for pic32_nibble_transmitter with a PIC32 echo model that
// records strobed nibbles and returns the ack after a random delay.
module tb_pic32_nibble_transmitter;

    localparam int SETUP_CYCLES = 8;
    localparam int ACK_TIMEOUT  = 100;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       pic_ack = 1'b0;
    logic [3:0] pic_data;
    logic       pic_strobe;
    logic       busy;
    logic       timeout;
    logic       timeout_clear = 1'b0;

    pic32_nibble_transmitter #(
        .FIFO_DEPTH   (4),
        .SETUP_CYCLES (SETUP_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pic_ack       (pic_ack),
        .pic_data      (pic_data),
        .pic_strobe    (pic_strobe),
        .busy          (busy),
        .timeout       (timeout),
        .timeout_clear (timeout_clear)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Controls written only by the stimulus process.
    logic mute = 1'b0;
    logic stall = 1'b0;
    int   spur_req = 0;
    int   rx_base = 0;

    // State written only by the PIC32 model.
    logic [3:0] rx_q[$];
    int         acks_done = 0;
    int         setup_bad = 0;
    int         spur_done = 0;
    int         stable_cnt = 0;
    int         ack_delay = 0;
    logic       prev_strobe = 1'b0;
    logic [3:0] prev_data = 4'h0;
    logic       pending = 1'b0;
    logic       ack_target = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            pic_ack     = 1'b0;
            prev_strobe = 1'b0;
            prev_data   = 4'h0;
            stable_cnt  = 0;
            pending     = 1'b0;
            spur_done   = spur_req;
        end else begin
            if (pic_data == prev_data) stable_cnt++;
            else stable_cnt = 1;
            prev_data = pic_data;
            if (pic_strobe != prev_strobe) begin
                prev_strobe = pic_strobe;
                if (!mute) begin
                    if (stable_cnt <= SETUP_CYCLES) setup_bad++;
                    rx_q.push_back(pic_data);
                    pending    = 1'b1;
                    ack_target = pic_strobe;
                    ack_delay  = $urandom_range(20, 3);
                end
            end
            if (pending && !stall) begin
                if (ack_delay == 0) begin
                    pic_ack = ack_target;
                    pending = 1'b0;
                    acks_done++;
                end else begin
                    ack_delay--;
                end
            end
            if (spur_req != spur_done) begin
                pic_ack   = ~pic_ack;
                spur_done = spur_req;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) check_eq("push_ready", in_ready, 1);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy && n < 3000);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_strobe_high(input string tag);
        int n = 0;
        while (!pic_strobe && n < 300) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_strobe_hi"}, pic_strobe, 1);
    endtask

    // bytes_v holds n bytes, first-sent byte in the most significant position.
    task automatic expect_bytes(input string tag, input int n, input logic [39:0] bytes_v);
        logic [7:0]  b;
        logic [31:0] got_hi, got_lo;
        int          idx;
        check_eq({tag, "_nibbles"}, rx_q.size() - rx_base, 2 * n);
        for (int i = 0; i < n; i++) begin
            b   = bytes_v[8*(n-1-i) +: 8];
            idx = rx_base + 2 * i;
            got_hi = (idx < rx_q.size())     ? {28'h0, rx_q[idx]}     : 32'hDEAD;
            got_lo = (idx + 1 < rx_q.size()) ? {28'h0, rx_q[idx + 1]} : 32'hDEAD;
            check_eq($sformatf("%s_b%0d_hi", tag, i), got_hi, {28'h0, b[7:4]});
            check_eq($sformatf("%s_b%0d_lo", tag, i), got_lo, {28'h0, b[3:0]});
        end
        rx_base = rx_q.size();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acks_before;

        // Reset state
        repeat (3) @(negedge clock);
        check_eq("rst_pic_data", pic_data, 0);
        check_eq("rst_strobe", pic_strobe, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 1: single byte
        push(8'hA5);
        check_eq("s1_busy", busy, 1);
        wait_idle("s1");
        expect_bytes("s1", 1, 40'hA5);
        check_eq("s1_strobe", pic_strobe, 0);
        check_eq("s1_timeout", timeout, 0);

        // 2: fill the FIFO while the PIC32 stalls, then drain
        stall = 1'b1;
        push(8'h12);
        push(8'h34);
        push(8'h56);
        push(8'h78);
        push(8'h9A);
        check_eq("s2_full", in_ready, 0);
        repeat (30) @(negedge clock);
        check_eq("s2_full_hold", in_ready, 0);
        check_eq("s2_busy", busy, 1);
        stall = 1'b0;
        wait_idle("s2");
        expect_bytes("s2", 5, 40'h12_34_56_78_9A);
        check_eq("s2_timeout", timeout, 0);

        // 3: no ack -> timeout after ACK_TIMEOUT+1 clocks in the wait state
        mute = 1'b1;
        push(8'hC3);
        wait_strobe_high("s3");
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!timeout && n < 4 * ACK_TIMEOUT);
        check_eq("s3_timeout_set", timeout, 1);
        check_eq("s3_expiry_delay", n, ACK_TIMEOUT + 1);
        check_eq("s3_realign", pic_strobe, pic_ack);
        check_eq("s3_idle", busy, 0);
        @(negedge clock);
        mute = 1'b0;
        rx_base = rx_q.size();
        push(8'h7E);
        wait_idle("s3b");
        expect_bytes("s3b", 1, 40'h7E);
        check_eq("s3_sticky", timeout, 1);
        timeout_clear = 1'b1;
        @(negedge clock);
        timeout_clear = 1'b0;
        check_eq("s3_cleared", timeout, 0);

        // 4: reset between the two nibbles of 0xF0
        acks_before = acks_done;
        push(8'hF0);
        n = 0;
        while (acks_done == acks_before && n < 300) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        check_eq("s4_mid_strobe", pic_strobe, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("s4_rst_data", pic_data, 0);
        check_eq("s4_rst_strobe", pic_strobe, 0);
        check_eq("s4_rst_busy", busy, 0);
        check_eq("s4_rst_in_ready", in_ready, 1);
        check_eq("s4_rst_timeout", timeout, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        rx_base = rx_q.size();
        push(8'h11);
        wait_idle("s4");
        expect_bytes("s4", 1, 40'h11);

        // 5: spurious ack toggle during SETUP_LO
        acks_before = acks_done;
        push(8'h69);
        n = 0;
        while (acks_done == acks_before && n < 300) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        check_eq("s5_in_setup_lo", pic_strobe, 1);
        spur_req++;
        wait_idle("s5");
        expect_bytes("s5", 1, 40'h69);
        repeat (30) @(negedge clock);
        check_eq("s5_no_extra", rx_q.size(), rx_base);
        check_eq("s5_phase", pic_strobe, pic_ack);

        // 6: clear coincides with expiry, later expiry sets again
        mute = 1'b1;
        push(8'h5A);
        wait_strobe_high("s6");
        repeat (ACK_TIMEOUT) @(negedge clock);
        check_eq("s6_pre_expiry", timeout, 0);
        timeout_clear = 1'b1;
        @(negedge clock);
        timeout_clear = 1'b0;
        check_eq("s6_clear_wins", timeout, 0);
        check_eq("s6_expired_idle", busy, 0);
        @(negedge clock);
        check_eq("s6_still_clear", timeout, 0);
        push(8'hA5);
        wait_strobe_high("s6b");
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!timeout && n < 4 * ACK_TIMEOUT);
        check_eq("s6_second_set", timeout, 1);
        check_eq("s6_realign", pic_strobe, pic_ack);
        @(negedge clock);
        mute = 1'b0;

        check_eq("setup_violations", setup_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
